// File: rtl/login_pkg.sv
// Shared definitions for the login front-end: FSM state encodings, the guest
// ID and the table of registered BCD user IDs.
// Optional feature macro: LOGIN_LOCKOUT_EN (adds the LOCKED state).
package login_pkg;

    localparam int MAX_USERS = 7;

    localparam logic [2:0] GUEST_ID = 3'd0;

    // Entry i holds the BCD user ID of internal ID i+1.
    localparam logic [15:0] USER_ID_TABLE [MAX_USERS] = '{
        16'h1234, 16'h5678, 16'h2468, 16'h1357, 16'h4321, 16'h8765, 16'h9021
    };

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_SEARCH  = 3'd2;
    localparam logic [2:0] ST_GRANTED = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
`ifdef LOGIN_LOCKOUT_EN
    localparam logic [2:0] ST_LOCKED  = 3'd5;
`endif

    // Out-of-range entries read as 0, which never matches a real login.
    function automatic logic [15:0] userIdAt(input int i);
        if (i >= 0 && i < MAX_USERS)
            return USER_ID_TABLE[i];
        else
            return 16'h0000;
    endfunction

endpackage

// File: rtl/user_id_rom.sv
// Constant user-ID table with two read ports: a combinational port for the
// login search and a registered port translating internal IDs for scoring.
import login_pkg::*;

module user_id_rom #(
    parameter int NUM_USERS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  searchIdx,
    output logic [15:0] searchData,
    input  logic [4:0]  lookupID,
    output logic [15:0] topID
);

    assign searchData = userIdAt(int'(searchIdx));

    // Registered lookup; guest (0) and IDs past the table translate to 0.
    always_ff @(posedge clk) begin
        if (!rst)
            topID <= 16'h0000;
        else if (lookupID == 5'd0 || int'(lookupID) > NUM_USERS)
            topID <= 16'h0000;
        else
            topID <= userIdAt(int'(lookupID) - 1);
    end

endmodule

// File: rtl/login_auth.sv
// Login front-end: collects a 4-digit BCD ID, searches the user table one
// entry per cycle and presents intID/isGuest to the scoring stage.
// Optional feature macro: LOGIN_LOCKOUT_EN (lockout after 3 consecutive
// failed logins for LOCK_CYCLES cycles).
import login_pkg::*;

module login_auth #(
    parameter int NUM_USERS   = 7,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digitIn,
    input  logic        digitValid,
    input  logic        guestReq,
    input  logic        clearReq,
    input  logic [4:0]  lookupID,
    output logic [15:0] topID,
    output logic [2:0]  intID,
    output logic        isGuest,
    output logic        loggedIn,
    output logic        authFail,
    output logic [2:0]  entryCount,
    output logic        locked
);

    // A zero-length lockout is meaningless; the block below only elaborates
    // for such a configuration and is left empty on purpose.
    if (LOCK_CYCLES < 1) begin : gLockCyclesInvalid
    end

    logic [2:0]  state;
    logic [15:0] idBuf;
    logic [2:0]  idx;
    logic [15:0] romData;
    logic        digitOk;
    logic        searchHit;
    logic        lastIdx;

`ifdef LOGIN_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    logic [1:0]        failCnt;
    logic [LOCK_W-1:0] lockCnt;
`endif

    user_id_rom #(.NUM_USERS(NUM_USERS)) uRom (
        .clk       (clk),
        .rst       (rst),
        .searchIdx (idx),
        .searchData(romData),
        .lookupID  (lookupID),
        .topID     (topID)
    );

    // Non-BCD digits are dropped as if no strobe arrived.
    assign digitOk   = digitValid && (digitIn <= 4'd9);
    // 0000 is reserved, so it can never log anyone in.
    assign searchHit = (idBuf != 16'h0000) && (idBuf == romData);
    assign lastIdx   = (int'(idx) == NUM_USERS - 1);

    assign loggedIn = (state == ST_GRANTED);
    assign authFail = (state == ST_FAIL);
`ifdef LOGIN_LOCKOUT_EN
    assign locked   = (state == ST_LOCKED);
`else
    assign locked   = 1'b0;
`endif

    // Login FSM with digit buffer, search index and session outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idBuf      <= 16'h0000;
            idx        <= 3'd0;
            entryCount <= 3'd0;
            intID      <= GUEST_ID;
            isGuest    <= 1'b1;
`ifdef LOGIN_LOCKOUT_EN
            failCnt    <= 2'd0;
            lockCnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (guestReq) begin
                        state   <= ST_GRANTED;
                        intID   <= GUEST_ID;
                        isGuest <= 1'b1;
`ifdef LOGIN_LOCKOUT_EN
                        failCnt <= 2'd0;
`endif
                    end else if (digitOk) begin
                        idBuf      <= {idBuf[11:0], digitIn};
                        entryCount <= 3'd1;
                        state      <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (clearReq) begin
                        idBuf      <= 16'h0000;
                        entryCount <= 3'd0;
                        state      <= ST_IDLE;
                    end else if (digitOk) begin
                        idBuf      <= {idBuf[11:0], digitIn};
                        entryCount <= entryCount + 3'd1;
                        if (entryCount == 3'd3) begin
                            state <= ST_SEARCH;
                            idx   <= 3'd0;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (searchHit) begin
                        state   <= ST_GRANTED;
                        intID   <= idx + 3'd1;
                        isGuest <= 1'b0;
`ifdef LOGIN_LOCKOUT_EN
                        failCnt <= 2'd0;
`endif
                    end else if (lastIdx) begin
                        state      <= ST_FAIL;
                        idBuf      <= 16'h0000;
                        entryCount <= 3'd0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_GRANTED: begin
                    if (clearReq) begin
                        state      <= ST_IDLE;
                        intID      <= GUEST_ID;
                        isGuest    <= 1'b1;
                        entryCount <= 3'd0;
                        idBuf      <= 16'h0000;
                    end
                end
                ST_FAIL: begin
                    idBuf      <= 16'h0000;
                    entryCount <= 3'd0;
`ifdef LOGIN_LOCKOUT_EN
                    failCnt <= failCnt + 2'd1;
                    if (failCnt == 2'd2) begin
                        state   <= ST_LOCKED;
                        lockCnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef LOGIN_LOCKOUT_EN
                ST_LOCKED: begin
                    if (lockCnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                        state   <= ST_IDLE;
                        failCnt <= 2'd0;
                        lockCnt <= '0;
                    end else begin
                        lockCnt <= lockCnt + 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_login_auth.sv
// Scoreboard bench for login_auth: stimulus pushes expected login/authFail
// events and topID values with the clock edge they must be sampled at; a
// negedge monitor pops and compares whenever the DUT presents one.
module tb_login_auth;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digitIn = 4'd0;
    logic        digitValid = 1'b0;
    logic        guestReq = 1'b0;
    logic        clearReq = 1'b0;
    logic [4:0]  lookupID = 5'd0;
    logic [15:0] topID;
    logic [2:0]  intID;
    logic        isGuest;
    logic        loggedIn;
    logic        authFail;
    logic [2:0]  entryCount;
    logic        locked;

    login_auth #(.NUM_USERS(7), .LOCK_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .digitIn(digitIn), .digitValid(digitValid),
        .guestReq(guestReq), .clearReq(clearReq), .lookupID(lookupID),
        .topID(topID), .intID(intID), .isGuest(isGuest), .loggedIn(loggedIn),
        .authFail(authFail), .entryCount(entryCount), .locked(locked)
    );

    always #5 clk = ~clk;

    // cyc = index of the most recent rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_LOGIN = 0;
    localparam int EV_FAIL  = 1;

    typedef struct {
        int         kind;
        int         edgeN;
        logic [2:0] id;
        logic       guest;
    } evT;

    typedef struct {
        int          edgeN;
        logic [15:0] val;
    } topT;

    evT  evQ[$];
    topT topQ[$];
    int  total = 0;
    int  bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: observes outputs before the next edge samples them.
    logic prevLog = 1'b0;
    always @(negedge clk) begin
        evT  e;
        topT t;
        int  k;
        logic hit;
        if (topQ.size() > 0 && topQ[0].edgeN == cyc + 1) begin
            t = topQ.pop_front();
            total++;
            if (topID !== t.val) begin
                bad++;
                $display("FAIL topID edge=%0d: got %h want %h", t.edgeN, topID, t.val);
            end
        end
        hit = 1'b0;
        k = EV_LOGIN;
        if (authFail) begin
            k = EV_FAIL;
            hit = 1'b1;
        end else if (loggedIn && !prevLog) begin
            k = EV_LOGIN;
            hit = 1'b1;
        end
        if (hit) begin
            total++;
            if (evQ.size() == 0) begin
                bad++;
                $display("FAIL event unexpected: kind=%0d edge=%0d intID=%0d isGuest=%0b",
                         k, cyc + 1, intID, isGuest);
            end else begin
                e = evQ.pop_front();
                if (e.kind != k || e.edgeN != cyc + 1 || intID !== e.id || isGuest !== e.guest) begin
                    bad++;
                    $display("FAIL event: got kind=%0d edge=%0d intID=%0d isGuest=%0b want kind=%0d edge=%0d intID=%0d isGuest=%0b",
                             k, cyc + 1, intID, isGuest, e.kind, e.edgeN, e.id, e.guest);
                end
            end
        end
        prevLog = loggedIn;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendDigit(input logic [3:0] d);
        digitIn = d;
        digitValid = 1'b1;
        tick();
        digitValid = 1'b0;
    endtask

    // Back-to-back digits; t = edge that sampled the 4th digit
    task automatic enterId(input logic [15:0] id, output int t);
        logic [15:0] v;
        v = id;
        for (int i = 3; i >= 0; i--) sendDigit(v[i*4 +: 4]);
        t = cyc;
    endtask

    task automatic expectEv(input int kind, input int edgeN, input logic [2:0] id, input logic g);
        evT e;
        e.kind = kind; e.edgeN = edgeN; e.id = id; e.guest = g;
        evQ.push_back(e);
    endtask

    task automatic lookup(input logic [4:0] id, input logic [15:0] exp);
        topT t;
        lookupID = id;
        tick();
        t.edgeN = cyc + 1;
        t.val = exp;
        topQ.push_back(t);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && evQ.size() > 0; i++) tick();
        check({"drain ", name}, evQ.size(), 0);
        evQ.delete();
    endtask

    task automatic doClear();
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
    endtask

    task automatic checkLoggedOut(input string name);
        check({name, " loggedIn"}, loggedIn, 0);
        check({name, " intID"}, intID, 0);
        check({name, " isGuest"}, isGuest, 1);
        check({name, " entryCount"}, entryCount, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int lockedCnt;

        // power-on reset
        tick(); tick();
        check("rst topID", topID, 0);
        checkLoggedOut("rst");
        check("rst authFail", authFail, 0);
        check("rst locked", locked, 0);
        rst = 1'b1;
        tick();

        // reset held two cycles in the middle of an entry
        sendDigit(4'd1);
        sendDigit(4'd2);
        check("midentry entryCount", entryCount, 2);
        lookupID = 5'd2;
        rst = 1'b0;
        tick(); tick();
        checkLoggedOut("midrst");
        check("midrst topID", topID, 0);
        check("midrst authFail", authFail, 0);
        rst = 1'b1;

        // lookup port, including out-of-range IDs
        lookup(5'd2, 16'h5678);
        lookup(5'd0, 16'h0000);
        lookup(5'd9, 16'h0000);
        lookup(5'd7, 16'h9021);
        lookup(5'd1, 16'h1234);
        lookupID = 5'd0;

        // first table entry: login at T+2
        enterId(16'h1234, t);
        expectEv(EV_LOGIN, t + 2, 3'd1, 1'b0);
        drain("1234");
        check("granted entryCount", entryCount, 4);
        // digits and guestReq ignored while logged in
        digitIn = 4'd5; digitValid = 1'b1; guestReq = 1'b1;
        tick();
        digitValid = 1'b0; guestReq = 1'b0;
        check("hold intID", intID, 1);
        check("hold isGuest", isGuest, 0);
        check("hold loggedIn", loggedIn, 1);
        doClear();
        checkLoggedOut("logout1");

        // last table entry: login at T+8
        enterId(16'h9021, t);
        expectEv(EV_LOGIN, t + 8, 3'd7, 1'b0);
        drain("9021");
        doClear();
        checkLoggedOut("logout7");

        // non-BCD digits are ignored, in IDLE and during entry
        sendDigit(4'hA);
        check("badDigit idle entryCount", entryCount, 0);
        sendDigit(4'd4);
        sendDigit(4'd3);
        sendDigit(4'hF);
        sendDigit(4'd2);
        sendDigit(4'd1);
        t = cyc;
        expectEv(EV_LOGIN, t + 2 + 4, 3'd5, 1'b0);
        drain("4321");
        doClear();

        // unknown ID and reserved 0000 both fail at T+8
        enterId(16'h1111, t);
        expectEv(EV_FAIL, t + 8, 3'd0, 1'b1);
        drain("1111");
        check("fail1 authFail", authFail, 0);
        checkLoggedOut("fail1");
        enterId(16'h0000, t);
        expectEv(EV_FAIL, t + 8, 3'd0, 1'b1);
        drain("0000");
        check("fail0 authFail", authFail, 0);
        checkLoggedOut("fail0");

        // clearReq wins over same-cycle digit
        sendDigit(4'd5);
        sendDigit(4'd6);
        check("partial entryCount", entryCount, 2);
        digitIn = 4'd7; digitValid = 1'b1; clearReq = 1'b1;
        tick();
        digitValid = 1'b0; clearReq = 1'b0;
        checkLoggedOut("abort");

        // guest login from IDLE at T+1
        guestReq = 1'b1;
        tick();
        guestReq = 1'b0;
        expectEv(EV_LOGIN, cyc + 1, 3'd0, 1'b1);
        drain("guest");
        check("guest intID", intID, 0);
        check("guest isGuest", isGuest, 1);
        doClear();
        checkLoggedOut("guestout");

`ifdef LOGIN_LOCKOUT_EN
        // three consecutive failures lock the front-end for 20 cycles
        for (int n = 0; n < 2; n++) begin
            enterId(16'h1111, t);
            expectEv(EV_FAIL, t + 8, 3'd0, 1'b1);
            drain("prelock");
        end
        enterId(16'h1111, t);
        expectEv(EV_FAIL, t + 8, 3'd0, 1'b1);
        lockedCnt = 0;
        digitIn = 4'd1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (locked) lockedCnt++;
            digitValid = locked;
            guestReq = locked;
        end
        digitValid = 1'b0;
        guestReq = 1'b0;
        check("lock duration", lockedCnt, 20);
        check("lock entryCount", entryCount, 0);
        check("lock released", locked, 0);
        check("lock loggedIn", loggedIn, 0);
        drain("lockfail");
        enterId(16'h1234, t);
        expectEv(EV_LOGIN, t + 2, 3'd1, 1'b0);
        drain("postlock");
        doClear();
`endif

        for (int i = 0; i < 5 && topQ.size() > 0; i++) tick();
        check("topQ empty", topQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
